// File: rtl/mult_seq_if.sv
// ============================================================================
// Module      : mult_seq_if
// Description : start/busy/done handshake and operand/result bus for mult_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_seq_if #(
   parameter int N = 32
);
   logic         start;
   logic         is_signed;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] hi;
   logic [N-1:0] lo;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, hi, lo
   );
endinterface

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module      : mult_seq
// Description : Iterative shift-add multiplier, one partial product per clock,
//               2N-bit signed/unsigned product split into hi/lo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder #(
   parameter int W = 8
) (
   input  wire logic [W-1:0] i_a,
   input  wire logic [W-1:0] i_b,
   output logic      [W-1:0] o_sum
);
   assign o_sum = i_a + i_b;
endmodule

module mult_seq #(
   parameter int N = 32
) (
   input  wire logic   clk,
   input  wire logic   reset,
   mult_seq_if.slave   bus
);
   localparam int            CW     = $clog2(N + 1);
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_busy;
   logic            r_done;
   logic            r_neg;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    r_mplier;
   logic [N-1:0]    r_acc;
   logic [N-1:0]    r_hi;
   logic [N-1:0]    r_lo;
   logic [CW-1:0]   r_count;

   logic            w_accept;
   logic [N-1:0]    w_a_mag;
   logic [N-1:0]    w_b_mag;
   logic [N-1:0]    w_addend;
   logic [N:0]      w_sum;
   logic [N-1:0]    w_acc_nxt;
   logic [N-1:0]    w_mplier_nxt;
   logic [2*N-1:0]  w_prod;
   logic [2*N-1:0]  w_result;

   assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_a_mag  = (bus.is_signed && bus.a[N-1]) ? -bus.a : bus.a;
   assign w_b_mag  = (bus.is_signed && bus.b[N-1]) ? -bus.b : bus.b;
   assign w_addend = r_mplier[0] ? r_mcand : '0;

   adder #(.W(N + 1)) u_adder (
      .i_a   ({1'b0, r_acc}),
      .i_b   ({1'b0, w_addend}),
      .o_sum (w_sum)
   );

   // Carry drops into the accumulator MSB; the accumulator LSB shifts into the multiplier.
   assign w_acc_nxt    = w_sum[N:1];
   assign w_mplier_nxt = {w_sum[0], r_mplier[N-1:1]};
   assign w_prod       = {w_acc_nxt, w_mplier_nxt};
   assign w_result     = r_neg ? -w_prod : w_prod;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (w_accept) begin
                  r_state  <= S_RUN;
                  r_busy   <= 1'b1;
                  r_neg    <= bus.is_signed && (bus.a[N-1] ^ bus.b[N-1]);
                  r_mcand  <= w_a_mag;
                  r_mplier <= w_b_mag;
                  r_acc    <= '0;
                  r_count  <= '0;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_nxt;
               r_mplier <= w_mplier_nxt;
               r_count  <= r_count + 1'b1;
               if (r_count == C_LAST) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_hi    <= w_result[2*N-1:N];
                  r_lo    <= w_result[N-1:0];
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Iterative shift-add multiplier for the ALU/HI-LO datapath. It drives the catalog `adder`, instantiated at width N+1 so the carry is kept, with one partial-product accumulation per clock. It produces a 2N-bit product split into `hi` and `lo` registers for MULT/MULTU. Handshake is start/busy/done, so the control unit stalls the pipeline while `busy` is high.

Parameters:
- N, 32, operand width in bits. The product is 2N bits; `hi` holds the upper N bits and `lo` the lower N bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high. Clears all state immediately.
- start  input  1  request a multiply. Sampled on the rising edge in IDLE or DONE only.
- is_signed  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU). Latched with `start`.
- a  input  N  multiplicand. Latched on an accepted `start`.
- b  input  N  multiplier. Latched on an accepted `start`.
- busy  output  1  high while the iteration is in progress.
- done  output  1  one-cycle pulse when `hi`/`lo` carry a new result.
- hi  output  N  upper product half. Registered and held until the next result.
- lo  output  N  lower product half. Registered and held until the next result.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, hi=0, lo=0; step counter=0; internal operand and accumulator registers=0.
- States:
  - IDLE: on start=1, go to RUN.
  - RUN: stay for exactly N steps, then go to DONE.
  - DONE: on start=1, go to RUN (back-to-back); otherwise go to IDLE.
- Accept edge (edge k, with start=1 in IDLE or DONE):
  - latch is_signed and the sign bits sa=a[N-1], sb=b[N-1] when signed;
  - latch magnitudes |a| and |b| (two's-complement negate when signed and the sign bit is 1; raw values otherwise);
  - clear the accumulator and counter; set busy=1.
- RUN step (one per edge):
  - if the multiplier LSB=1, accumulator[N:0] = accumulator upper N bits + multiplicand, with the carry kept in bit N;
  - then shift the {carry, acc_hi, multiplier} concatenation right by 1;
  - counter increments.
- Final step and result timing:
  - At the edge of step N (edge k+N): transition to DONE, busy=0, done=1.
  - `hi`/`lo` load the final 2N-bit product on that edge, negated (2N-bit two's complement) iff is_signed and sa XOR sb.
  - `hi`/`lo` are valid in the same cycle `done` is high.
- Latency: busy is high for exactly N cycles (edges k+1..k+N). done is high for exactly 1 cycle, then clears, unless a new start in DONE restarts the multiply.
- Input stability: a, b and is_signed may change during RUN with no effect on the result (operands are latched).
- start during RUN: ignored; no restart, no queueing.
- hi/lo: change only on the DONE-entry edge or on reset. They hold the previous result through IDLE and the whole of the next RUN.
- Widths and edge cases:
  - The magnitude of the most negative value (-2^(N-1)) fits in N unsigned bits.
  - Signed (-2^(N-1))·(-2^(N-1)) = 2^(2N-2), which is representable with no overflow.
  - There are no overflow flags.
- Reset asserted mid-RUN: aborts the operation. busy, done, hi and lo go to 0 immediately. No done pulse is produced for the aborted operation.
- Zero operand: the full N cycles are still taken; there is no early termination, so latency is fixed.

Test Plan:
- Unsigned a=3, b=5, start for 1 cycle -> busy high for 32 cycles; done pulses 1 cycle on edge k+32; hi=0x00000000, lo=0x0000000F.
- Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Second case a=0x80000000, b=2 -> hi=0x00000001, lo=0x00000000.
- Signed cases:
  - a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1;
  - a=-1, b=-1 -> hi=0, lo=1;
  - a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Change a/b and pulse start at cycle 10 of RUN -> ignored. The result matches the originally latched operands and done fires once at k+32. Then start during the DONE cycle -> busy=1 on the next edge; the new result arrives 32 edges later.
- Reset asserted asynchronously (mid-clock) during RUN cycle 16 -> busy, done, hi and lo read 0 before the next edge. After release, no done pulse appears; a new 7×6 unsigned operation yields lo=42.
- Idle hold: after a result, 50 cycles with no start -> hi/lo unchanged, done=0, busy=0.
